c_rr_index_arbiter: RTL and testbench
=====================================

# c_rr_index_arbiter

Round-robin arbiter with packet locking that produces a registered binary grant index and a binary priority pointer. It sits directly upstream of the team's binary-to-one-hot / thermometer decoder. `gnt_idx` feeds a one-hot decode to drive output-port selects. `ptr` feeds a thermometer decode (`therm_enc=1`) to build priority masks elsewhere in the router. Used per output port in switch and VC allocation.

## Interface
- `num_ports`, 8: number of requesters, ≥2, need not be a power of two.
- `lock_enable`, 1: 1 = grant held across multi-cycle packets until `tail`; 0 = `tail` internally forced to 1.
- Derived `width` = clogb(num_ports).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  [0:num_ports-1]  request vector; bit i = port i requests.
- `ack`  in  1  consumer accepts the current grant this cycle.
- `tail`  in  1  qualifies `ack`: the accepted transfer is the last of its packet.
- `gnt_valid`  out  1  registered; a grant is held.
- `gnt_idx`  out  [0:width-1]  registered binary index of the granted port.
- `locked`  out  1  registered; a packet is in progress (non-tail ack seen).
- `ptr`  out  [0:width-1]  registered priority pointer; the highest-priority port for the next arbitration.

## Operation
- States:
  - IDLE (`gnt_valid=0`)
  - GRANT (`gnt_valid=1`, `locked=0`)
  - LOCK (`gnt_valid=1`, `locked=1`)
- Selection function `sel(p, r)`: first index j in cyclic order p, p+1, …, num_ports-1, 0, …, p-1 with r[j]=1. It is defined only if |r ≠ 0. Indices ≥ num_ports are never produced.
- IDLE:
  - If |req, next state is GRANT with `gnt_idx <= sel(ptr, req)`.
  - Otherwise stay in IDLE; `gnt_idx` holds its value.
- GRANT or LOCK, no `ack`: hold all outputs.
  - `req` is ignored, including withdrawal of req[gnt_idx]. A grant is never revoked except by reset.
- GRANT or LOCK, `ack & !tail_eff`: go to or stay in LOCK. `gnt_idx` and `ptr` are unchanged.
- GRANT or LOCK, `ack & tail_eff`:
  - `ptr <= (gnt_idx+1) mod num_ports`, written as 0 when gnt_idx = num_ports-1.
  - `locked <= 0`.
  - Same-cycle re-arbitration using the new pointer value p' = (gnt_idx+1) mod num_ports: if |req, go to GRANT with `gnt_idx <= sel(p', req)`, with no bubble cycle. Otherwise go to IDLE.
  - The just-released port may win again if it is the only requester.
- `tail_eff` = `tail | !lock_enable`.
- `ack` while in IDLE is ignored. `tail` without `ack` is ignored.
- `ptr` changes only on `ack & tail_eff`.
- Reset (asynchronous, on the `reset` falling edge, regardless of clock): `gnt_valid=0`, `gnt_idx=0`, `locked=0`, `ptr=0`, state IDLE.
  - Reset mid-packet drops the grant and lock with no further side effects.
  - First arbitration happens on the first rising edge after `reset` deasserts with |req.

## Timing
- Request to grant: 1 cycle. `req` sampled at edge N gives `gnt_valid`/`gnt_idx` valid after edge N.
- Back-to-back grants: on `ack & tail`, the next grant is visible after the same edge; throughput is 1 packet per cycle.
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.
- `ptr` is visible after the edge that samples `ack & tail_eff`, so downstream thermometer decode sees it one cycle after the release.

## Test plan
- Reset: drive `reset=0` mid-cycle with `req=8'hFF` → outputs immediately read `gnt_valid=0`, `gnt_idx=0`, `locked=0`, `ptr=0`. After release, the first edge gives `gnt_idx=0`.
- Fairness, num_ports=8: `req` bits 2 and 5 set, `ptr=0` → `gnt_idx=2`. Then `ack=1`, `tail=1` → after the edge `gnt_idx=5`, `ptr=3`, `gnt_valid` stays 1 with no bubble. `ack`, `tail` again with only port 2 requesting → `gnt_idx=2`, `ptr=6`.
- Wrap: `ptr=6`, only `req[1]` set → `gnt_idx=1`. `ack & tail` with `req=0` → `ptr=2`, `gnt_valid=0`.
- Lock: grant at index 3 with all requests set. `ack=1`, `tail=0` for 3 cycles → `gnt_idx=3`, `locked=1`, `ptr` unchanged throughout. `ack`, `tail` → `locked=0`, `ptr=4`, `gnt_idx=4`. Repeat with `lock_enable=0` → the first ack releases (`ptr=4` after one cycle).
- Hold: grant at index 2, drop `req[2]` and assert `req[7]`, no `ack` for 5 cycles → `gnt_idx` stays 2, `gnt_valid=1`. Additionally, `ack` in IDLE → no state change.
- Non-power-of-two, num_ports=5 (width 3): grant at index 4, `ack & tail` → `ptr=0`. With all requests set, `gnt_idx` cycles 0,1,2,3,4,0 and never reaches 5–7.

Source files
------------

// File: rtl/c_rr_index_arbiter.sv
// Round-robin arbiter with packet locking; registered binary grant index and priority pointer.
// Grant one edge after request; a held grant is released only by ack & tail (or reset).
module c_rr_index_arbiter #(
  parameter int num_ports   = 8,
  parameter bit lock_enable = 1'b1,
  localparam int width      = (num_ports > 1) ? $clog2(num_ports) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [0:num_ports-1] req,
  input  logic                 ack,
  input  logic                 tail,
  output logic                 gnt_valid,
  output logic [0:width-1]     gnt_idx,
  output logic                 locked,
  output logic [0:width-1]     ptr
);

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_grant = 2'd1,
    st_lock  = 2'd2
  } state_t;

  localparam logic [width-1:0] last_idx = width'(num_ports - 1);

  state_t           state;
  logic             tail_eff;
  logic             any_req;
  logic [width-1:0] rel_ptr;
  logic [width-1:0] arb_ptr;
  logic [width-1:0] arb_idx;

  // First requester at or after p in cyclic order; lowest requester covers the wrap.
  function automatic logic [width-1:0] sel_fn(input logic [width-1:0] p,
                                              input logic [0:num_ports-1] r);
    logic             hi_found;
    logic [width-1:0] hi;
    logic [width-1:0] lo;
    hi_found = 1'b0;
    hi       = '0;
    lo       = '0;
    for (int j = num_ports - 1; j >= 0; j--) begin
      if (r[j]) begin
        lo = width'(j);
        if (j >= int'(p)) begin
          hi       = width'(j);
          hi_found = 1'b1;
        end
      end
    end
    return hi_found ? hi : lo;
  endfunction

  always_comb begin
    tail_eff = tail | !lock_enable;
    any_req  = |req;
    rel_ptr  = (gnt_idx == last_idx) ? '0 : gnt_idx + width'(1);
    // Re-arbitration on release uses the post-release pointer so there is no bubble.
    arb_ptr  = (state == st_idle) ? ptr : rel_ptr;
    arb_idx  = sel_fn(arb_ptr, req);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= st_idle;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      locked    <= 1'b0;
      ptr       <= '0;
    end else begin
      case (state)
        st_idle: begin
          if (any_req) begin
            state     <= st_grant;
            gnt_valid <= 1'b1;
            gnt_idx   <= arb_idx;
          end
        end
        st_grant, st_lock: begin
          if (ack) begin
            if (!tail_eff) begin
              state  <= st_lock;
              locked <= 1'b1;
            end else begin
              ptr    <= rel_ptr;
              locked <= 1'b0;
              if (any_req) begin
                state     <= st_grant;
                gnt_valid <= 1'b1;
                gnt_idx   <= arb_idx;
              end else begin
                state     <= st_idle;
                gnt_valid <= 1'b0;
              end
            end
          end
        end
        default: begin
          state     <= st_idle;
          gnt_valid <= 1'b0;
          locked    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c_rr_index_arbiter.sv
// Bench for c_rr_index_arbiter: directed scenarios with literal expectations, then random traffic
// against a cyclic-search reference model on an 8-port locking and a 5-port non-locking instance.
module tb_c_rr_index_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [0:7] req8 = '0;
  logic [0:4] req5 = '0;
  logic       ack8 = 1'b0, tail8 = 1'b0, ack5 = 1'b0, tail5 = 1'b0;
  logic       gv8, lk8, gv5, lk5;
  logic [0:2] gi8, pt8, gi5, pt5;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  chk_en   = 1'b0;

  always #5 clk = ~clk;

  c_rr_index_arbiter #(.num_ports(8), .lock_enable(1'b1)) u8 (
    .clk(clk), .reset(reset), .req(req8), .ack(ack8), .tail(tail8),
    .gnt_valid(gv8), .gnt_idx(gi8), .locked(lk8), .ptr(pt8));

  c_rr_index_arbiter #(.num_ports(5), .lock_enable(1'b0)) u5 (
    .clk(clk), .reset(reset), .req(req5), .ack(ack5), .tail(tail5),
    .gnt_valid(gv5), .gnt_idx(gi5), .locked(lk5), .ptr(pt5));

  // Reference model: index 0 = 8-port locking, index 1 = 5-port non-locking.
  int mv[2] = '{0, 0};
  int mi[2] = '{0, 0};
  int ml[2] = '{0, 0};
  int mp[2] = '{0, 0};
  int np[2] = '{8, 5};
  bit mle[2] = '{1'b1, 1'b0};

  function automatic int sel(int p, int n, bit [7:0] r);
    for (int k = 0; k < n; k++) begin
      if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic step(int i, bit [7:0] r, bit a, bit t);
    if (mv[i] == 0) begin
      if (r != 0) begin
        mv[i] = 1;
        mi[i] = sel(mp[i], np[i], r);
      end
    end else if (a) begin
      if (t || !mle[i]) begin
        mp[i] = (mi[i] + 1) % np[i];
        ml[i] = 0;
        if (r != 0) mi[i] = sel(mp[i], np[i], r);
        else        mv[i] = 0;
      end else begin
        ml[i] = 1;
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    bit [7:0] r0, r1;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        mv[i] = 0; mi[i] = 0; ml[i] = 0; mp[i] = 0;
      end
    end else begin
      r0 = '0;
      r1 = '0;
      for (int j = 0; j < 8; j++) r0[j] = req8[j];
      for (int j = 0; j < 5; j++) r1[j] = req5[j];
      step(0, r0, ack8, tail8);
      step(1, r1, ack5, tail5);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m8_valid",  32'(gv8), 32'(mv[0]));
      chk("m8_idx",    32'(gi8), 32'(mi[0]));
      chk("m8_locked", 32'(lk8), 32'(ml[0]));
      chk("m8_ptr",    32'(pt8), 32'(mp[0]));
      chk("m5_valid",  32'(gv5), 32'(mv[1]));
      chk("m5_idx",    32'(gi5), 32'(mi[1]));
      chk("m5_locked", 32'(lk5), 32'(ml[1]));
      chk("m5_ptr",    32'(pt5), 32'(mp[1]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set8(bit [7:0] ports, bit a, bit t);
    for (int j = 0; j < 8; j++) req8[j] = ports[j];
    ack8  = a;
    tail8 = t;
  endtask

  task automatic exp8(string name, int v, int idx, int lk, int p);
    chk({name, "_valid"},  32'(gv8), 32'(v));
    chk({name, "_idx"},    32'(gi8), 32'(idx));
    chk({name, "_locked"}, 32'(lk8), 32'(lk));
    chk({name, "_ptr"},    32'(pt8), 32'(p));
  endtask

  initial begin
    bit [7:0] seq5[6];
    int       dens;

    reset = 1'b0;
    repeat (3) cyc();
    reset  = 1'b1;
    chk_en = 1'b1;
    exp8("rst0", 0, 0, 0, 0);

    // Async reset in the middle of a held grant.
    set8(8'hFF, 0, 0);
    cyc(); exp8("first", 1, 0, 0, 0);
    set8(8'hFF, 1, 1);
    cyc(); exp8("b2b0", 1, 1, 0, 1);
    set8(8'hFF, 0, 0);
    reset = 1'b0;
    #1; exp8("async_rst", 0, 0, 0, 0);
    cyc();
    reset = 1'b1;
    cyc(); exp8("post_rst", 1, 0, 0, 0);
    reset = 1'b0;
    set8(8'h00, 0, 0);
    cyc();
    reset = 1'b1;

    // Fairness: ports 2 and 5 with ptr=0.
    set8(8'b0010_0100, 0, 0);
    cyc(); exp8("fair_a", 1, 2, 0, 0);
    set8(8'b0010_0100, 1, 1);
    cyc(); exp8("fair_b", 1, 5, 0, 3);
    set8(8'b0000_0100, 1, 1);
    cyc(); exp8("fair_c", 1, 2, 0, 6);

    // Wrap: park ptr at 6 then only port 1 requests.
    set8(8'b0010_0000, 1, 1);
    cyc(); exp8("wrap_a", 1, 5, 0, 3);
    set8(8'h00, 1, 1);
    cyc(); exp8("wrap_b", 0, 5, 0, 6);
    set8(8'b0000_0010, 0, 0);
    cyc(); exp8("wrap_c", 1, 1, 0, 6);
    set8(8'h00, 1, 1);
    cyc(); exp8("wrap_d", 0, 1, 0, 2);

    // Lock: grant at 3, three non-tail acks, then tail.
    set8(8'hFF, 0, 0);
    cyc(); exp8("lock_a", 1, 2, 0, 2);
    set8(8'hFF, 1, 1);
    cyc(); exp8("lock_b", 1, 3, 0, 3);
    set8(8'hFF, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(); exp8("lock_hold", 1, 3, 1, 3);
    end
    set8(8'hFF, 1, 1);
    cyc(); exp8("lock_rel", 1, 4, 0, 4);

    // Hold: grant at 2, request withdrawn, no ack.
    set8(8'h00, 1, 1);
    cyc(); exp8("hold_a", 0, 4, 0, 5);
    set8(8'b0000_0100, 0, 0);
    cyc(); exp8("hold_b", 1, 2, 0, 5);
    set8(8'b1000_0000, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(); exp8("hold", 1, 2, 0, 5);
    end
    set8(8'h00, 1, 1);
    cyc(); exp8("hold_rel", 0, 2, 0, 3);
    for (int k = 0; k < 2; k++) begin
      cyc(); exp8("idle_ack", 0, 2, 0, 3);
    end
    set8(8'h00, 0, 0);

    // 5 ports, no locking: non-tail ack releases; index sequence wraps 4 -> 0.
    req5 = '1;
    cyc();
    chk("p5_first", 32'(gi5), 32'd0);
    ack5 = 1'b1; tail5 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc(); chk("p5_seq", 32'(gi5), 32'(k));
    end
    tail5 = 1'b0;
    cyc();
    chk("p5_nolock_idx", 32'(gi5), 32'd4);
    chk("p5_nolock_ptr", 32'(pt5), 32'd4);
    chk("p5_nolock_lk",  32'(lk5), 32'd0);
    tail5 = 1'b1;
    cyc();
    chk("p5_wrap_ptr", 32'(pt5), 32'd0);
    chk("p5_wrap_idx", 32'(gi5), 32'd0);
    chk("p5_wrap_vld", 32'(gv5), 32'd1);
    ack5 = 1'b0; tail5 = 1'b0; req5 = '0;
    seq5[0] = '0;

    // Random traffic with occasional asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) dens = $urandom_range(5, 90);
      for (int j = 0; j < 8; j++) req8[j] = ($urandom_range(0, 99) < dens);
      for (int j = 0; j < 5; j++) req5[j] = ($urandom_range(0, 99) < dens);
      ack8  = ($urandom_range(0, 3) != 0);
      tail8 = $urandom_range(0, 1) == 1;
      ack5  = ($urandom_range(0, 3) != 0);
      tail5 = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 299) == 0) reset = 1'b0;
      else                             reset = 1'b1;
      cyc();
    end
    reset = 1'b1;
    cyc();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
